// File: rtl/tbird_pkg.sv
// Shared constants and helpers for the Thunderbird switch conditioner.
// Optional hazard output is enabled by defining TBIRD_HAZARD_EN.
package tbird_pkg;

  // Board default: 10 ms at 50 MHz.
  localparam int TBIRD_DB_CYCLES     = 500000;
  localparam int TBIRD_CNT_W         = 19;
  // Short debounce window used by simulation benches.
  localparam int TBIRD_DB_CYCLES_SIM = 4;

  // Which debounced switches are currently asserted.
  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_LEFT  = 2'd1,
    REQ_RIGHT = 2'd2,
    REQ_BOTH  = 2'd3
  } req_e;

  // Collapse the two debounced levels into a request class.
  function automatic req_e classify_req(input logic db_l, input logic db_r);
    req_e req;
    case ({db_l, db_r})
      2'b10:   req = REQ_LEFT;
      2'b01:   req = REQ_RIGHT;
      2'b11:   req = REQ_BOTH;
      default: req = REQ_NONE;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/tbird_switch_conditioner_debounce.sv
// One switch channel: two-flop synchroniser followed by a stability counter.
// The debounced level flips only after DB_CYCLES consecutive edges on which
// the synchronised input disagrees with it; any agreeing edge restarts the count.
module tbird_debounce
  import tbird_pkg::*;
#(
  parameter int DB_CYCLES = TBIRD_DB_CYCLES,
  parameter int CNT_W     = TBIRD_CNT_W
) (
  input  logic Clk,
  input  logic Rs,
  input  logic raw,
  output logic db
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive disagreement edges and flip the level on the last one.
  always_comb begin
    db_d  = db_q;
    cnt_d = {CNT_W{1'b0}};
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = s2_q;
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Synchroniser chain, debounced level and counter; reset clears everything.
  always_ff @(posedge Clk) begin
    if (Rs) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/tbird_switch_conditioner.sv
// Conditions the raw left/right turn switches into clean registered levels
// for the tail-light sequencer. Define TBIRD_HAZARD_EN to map "both held"
// onto the Haz output instead of passing L=R=1 through.
module tbird_switch_conditioner
  import tbird_pkg::*;
#(
  parameter int DB_CYCLES = TBIRD_DB_CYCLES,
  parameter int CNT_W     = TBIRD_CNT_W
) (
  input  logic Clk,
  input  logic Rs,
  input  logic L_raw,
  input  logic R_raw,
  output logic L,
  output logic R,
  output logic Haz
);

  logic db_l;
  logic db_r;
  req_e req_s;
  logic l_d;
  logic r_d;
  logic l_q;
  logic r_q;
`ifdef TBIRD_HAZARD_EN
  logic haz_d;
  logic haz_q;
`endif

  tbird_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_l (
    .Clk (Clk),
    .Rs  (Rs),
    .raw (L_raw),
    .db  (db_l)
  );

  tbird_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_r (
    .Clk (Clk),
    .Rs  (Rs),
    .raw (R_raw),
    .db  (db_r)
  );

  assign req_s = classify_req(db_l, db_r);

  // Map the debounced request class onto the output levels.
  always_comb begin
    l_d = 1'b0;
    r_d = 1'b0;
`ifdef TBIRD_HAZARD_EN
    haz_d = 1'b0;
`endif
    case (req_s)
      REQ_LEFT:  l_d = 1'b1;
      REQ_RIGHT: r_d = 1'b1;
      REQ_BOTH: begin
`ifdef TBIRD_HAZARD_EN
        haz_d = 1'b1;
`else
        l_d = 1'b1;
        r_d = 1'b1;
`endif
      end
      default: begin
        l_d = 1'b0;
        r_d = 1'b0;
      end
    endcase
  end

  // Output register so the divided-clock sequencer sees glitch-free levels.
  always_ff @(posedge Clk) begin
    if (Rs) begin
      l_q <= 1'b0;
      r_q <= 1'b0;
`ifdef TBIRD_HAZARD_EN
      haz_q <= 1'b0;
`endif
    end else begin
      l_q <= l_d;
      r_q <= r_d;
`ifdef TBIRD_HAZARD_EN
      haz_q <= haz_d;
`endif
    end
  end

  assign L = l_q;
  assign R = r_q;
`ifdef TBIRD_HAZARD_EN
  assign Haz = haz_q;
`else
  assign Haz = 1'b0;
`endif

endmodule

// File: tb/tb_tbird_switch_conditioner.sv
// Scoreboard bench for tbird_switch_conditioner with a short debounce window.
// The reference model treats each channel as a two-sample delay line feeding
// a sliding window: the level flips once the last DB samples all disagree.
module tb_tbird_switch_conditioner;
  import tbird_pkg::*;

  localparam int DB = TBIRD_DB_CYCLES_SIM;
  localparam int CW = 3;

  logic Clk;
  logic Rs;
  logic L_raw;
  logic R_raw;
  logic L;
  logic R;
  logic Haz;

  int checks;
  int errors;
  int cycle_no;

  // Expected {L,R,Haz} after each rising edge, oldest first.
  logic [2:0] exp_q[$];

  // Reference model state.
  bit m_s1[2];
  bit m_s2[2];
  bit m_db[2];
  bit hist[2][$];

  tbird_switch_conditioner #(.DB_CYCLES(DB), .CNT_W(CW)) u_dut (
    .Clk   (Clk),
    .Rs    (Rs),
    .L_raw (L_raw),
    .R_raw (R_raw),
    .L     (L),
    .R     (R),
    .Haz   (Haz)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance the model by one rising edge and queue the resulting outputs.
  task automatic model_edge(input bit rs, input bit lraw, input bit rraw);
    bit raw[2];
    bit all_mis;
    logic [2:0] e;
    raw[0] = lraw;
    raw[1] = rraw;
    if (rs) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 1'b0;
        m_s2[c] = 1'b0;
        m_db[c] = 1'b0;
        hist[c].delete();
      end
      e = 3'b000;
    end else begin
      if (m_db[0] && m_db[1]) begin
`ifdef TBIRD_HAZARD_EN
        e = 3'b001;
`else
        e = 3'b110;
`endif
      end else begin
        e = {m_db[0], m_db[1], 1'b0};
      end
      for (int c = 0; c < 2; c++) begin
        hist[c].push_back(m_s2[c]);
        if (hist[c].size() > DB) void'(hist[c].pop_front());
        all_mis = (hist[c].size() == DB);
        for (int i = 0; i < hist[c].size(); i++)
          if (hist[c][i] == m_db[c]) all_mis = 1'b0;
        if (all_mis) m_db[c] = ~m_db[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
    end
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus away from the edge, then model that edge.
  task automatic cycle(input bit rs, input bit lraw, input bit rraw);
    @(negedge Clk);
    Rs    = rs;
    L_raw = lraw;
    R_raw = rraw;
    @(posedge Clk);
    model_edge(rs, lraw, rraw);
    cycle_no++;
  endtask

  task automatic hold(input int n, input bit rs, input bit lraw, input bit rraw);
    for (int i = 0; i < n; i++) cycle(rs, lraw, rraw);
  endtask

  // Monitor: the DUT presents fresh outputs every cycle; compare on the falling edge.
  always @(negedge Clk) begin
    logic [2:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({L, R, Haz} !== e) begin
        errors++;
        $display("FAIL out_LRH cycle %0d: got %b expected %b", cycle_no, {L, R, Haz}, e);
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    cycle_no = 0;
    Rs       = 1'b1;
    L_raw    = 1'b1;
    R_raw    = 1'b1;

    // Reset with both raw switches high.
    hold(2, 1'b1, 1'b1, 1'b1);
    hold(4, 1'b0, 1'b0, 1'b0);

    // Clean press and release on the left channel.
    hold(12, 1'b0, 1'b1, 1'b0);
    hold(12, 1'b0, 1'b0, 1'b0);

    // Right glitch shorter than the window.
    hold(3, 1'b0, 1'b0, 1'b1);
    hold(20, 1'b0, 1'b0, 1'b0);

    // Left bounce every two cycles, then settle high, then release.
    for (int i = 0; i < 10; i++) hold(2, 1'b0, i[0], 1'b0);
    hold(12, 1'b0, 1'b1, 1'b0);
    hold(12, 1'b0, 1'b0, 1'b0);

    // Both held, then drop right, then release all.
    hold(12, 1'b0, 1'b1, 1'b1);
    hold(12, 1'b0, 1'b1, 1'b0);
    hold(12, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a left debounce count.
    hold(4, 1'b0, 1'b1, 1'b0);
    hold(1, 1'b1, 1'b1, 1'b0);
    hold(12, 1'b0, 1'b1, 1'b0);
    hold(12, 1'b0, 1'b0, 1'b0);

    // Randomised holds with occasional resets.
    for (int i = 0; i < 120; i++) begin
      bit rl;
      bit rr;
      bit rs;
      int n;
      rl = 1'($urandom_range(1, 0));
      rr = 1'($urandom_range(1, 0));
      rs = ($urandom_range(39, 0) == 0);
      n  = rs ? 1 : int'($urandom_range(8, 1));
      hold(n, rs, rl, rr);
    end
    hold(10, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain the last expectation.
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tbird_switch_conditioner.md
Name: tbird_switch_conditioner

Overview:
- Upstream input stage for the Thunderbird tail-light sequencer.
- Takes the raw, bouncing, asynchronous left/right turn switches.
- Synchronises each switch to Clk, debounces it with a per-channel stability counter, and resolves the both-switches case.
- Drives clean, registered L/R levels (and an optional hazard level) that the sequencer, running on the divided clock, samples directly.

Parameters:
- DB_CYCLES, 500000, number of consecutive Clk cycles an input must hold a new value before the output follows (10 ms at 50 MHz). Must be ≥ 2.
- CNT_W, 19, debounce counter width. Must satisfy 2^CNT_W ≥ DB_CYCLES.

Ports:
- Clk  input  1  system clock (undivided board clock)
- Rs  input  1  reset, synchronous, active-high
- L_raw  input  1  raw left switch, asynchronous, may bounce
- R_raw  input  1  raw right switch, asynchronous, may bounce
- L  output  1  conditioned left request (level)
- R  output  1  conditioned right request (level)
- Haz  output  1  both switches held (meaningful only with the optional feature)

Behaviour:
- Clocking and reset:
  - Single clock Clk. All flops update on the rising edge.
  - Rs is synchronous and active-high. While Rs=1 at an edge, the following are cleared to 0: both 2-flop synchronisers, debounced states, counters, L, R and Haz.
  - Reset values: L=0, R=0, Haz=0.
- Synchroniser (per channel): two-flop chain raw→s1→s2. Nothing downstream uses s1.
- Debounce (per channel): state register db (reset 0) and counter cnt (reset 0).
  - If s2==db: cnt<=0.
  - If s2!=db and cnt<DB_CYCLES-1: cnt<=cnt+1.
  - If s2!=db and cnt==DB_CYCLES-1: db<=s2, cnt<=0.
  - db therefore flips at the DB_CYCLES-th consecutive mismatch edge.
  - Any single cycle with s2==db restarts the count. Pulses shorter than DB_CYCLES cycles never reach db.
  - cnt never exceeds DB_CYCLES-1. No wrap-around is possible.
- Output stage (registered, one cycle):
  - One of dbL/dbR high → L=dbL, R=dbR, Haz=0.
  - Neither high → all outputs 0.
  - Both high → see Optional Feature.
- Latency:
  - A raw change stable from before edge k appears on the output after edge k+DB_CYCLES+2, i.e. DB_CYCLES+3 edges total (2 sync, DB_CYCLES debounce, 1 output).
  - Release (1→0) uses identical latency and is symmetric.
- Simultaneous events:
  - Channels are fully independent until the output stage.
  - Rs wins over every other condition on the same edge.
- Reset mid-count: counters clear. After Rs falls, a held input needs the full DB_CYCLES+3 edges again.
- Output stability: outputs change at most once per DB_CYCLES cycles per channel. This guarantees the divided-clock sequencer never sees a glitch.

Optional Feature:
- Macro: TBIRD_HAZARD_EN.
- Defined:
  - dbL=1 and dbR=1 → registered L=0, R=0, Haz=1.
  - Exiting hazard (either db falls) → normal L/R mapping on the next output edge.
- Not defined:
  - Both high → L=1, R=1 passed through.
  - Haz port remains present and is tied to constant 0.

Decomposition:
- Package tbird_pkg:
  - default debounce constants (TBIRD_DB_CYCLES=500000, TBIRD_CNT_W=19);
  - a simulation constant TBIRD_DB_CYCLES_SIM=4 for benches.
- Sub-module tbird_debounce:
  - one channel: synchroniser + counter + db state;
  - ports Clk, Rs, raw, db;
  - instantiated twice.
- Top holds the output/hazard stage only.

Test Plan (DB_CYCLES=4, CNT_W=3):
- Reset: Rs=1 for 2 edges with L_raw=R_raw=1 → L=R=Haz=0 throughout and on the edge Rs first samples 1.
- Clean press: L_raw 0→1 before edge 0 and held → L=1 exactly after edge 6 (7 edges), R=0, Haz=0. Release behaves the same: L=0 after 7 edges.
- Glitch reject: R_raw high for 3 cycles, then low → R stays 0 for 20 cycles; internal cnt returns to 0.
- Bounce: L_raw toggles every 2 cycles for 20 cycles, then stays 1 → L remains 0 during bouncing and rises 7 edges after the final 0→1 transition.
- Both held: L_raw=R_raw=1 together →
  - with TBIRD_HAZARD_EN: Haz=1, L=R=0 after 7 edges; dropping R_raw gives Haz=0, L=1 after 7 more edges;
  - without the macro: L=R=1, Haz=0.
- Reset mid-count: L_raw=1, Rs=1 on the 3rd debounce edge for 1 cycle → L=0, and L rises only 7 edges after Rs returns to 0.
